// File: rtl/grid_pkg.sv
// Shared defaults and helpers for the double-buffered cell grid and its
// pixel-position counter.
package grid_pkg;

  localparam int DEF_X_SIZE = 640;
  localparam int DEF_Y_SIZE = 480;
  localparam int DEF_GRID_W = 4;
  localparam int DEF_GRID_H = 3;

  // Commit FSM encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cell_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned grid_w);
    return row * grid_w + col;
  endfunction

endpackage

// File: rtl/grid_pos_counter.sv
// Tracks the current pixel as (cell column, sub-cell x, cell row, sub-cell y)
// so the cell lookup needs no division; also produces sof/eol/eof framing.
module grid_pos_counter
  import grid_pkg::*;
#(
  parameter int CELL_W = 160,
  parameter int CELL_H = 160,
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  localparam int COL_W = clog2_min1(GRID_W),
  localparam int ROW_W = clog2_min1(GRID_H)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pix_adv_i,
  output logic [COL_W-1:0] cc_o,
  output logic [ROW_W-1:0] cr_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             eof_o
);

  localparam int SX_W = clog2_min1(CELL_W);
  localparam int SY_W = clog2_min1(CELL_H);

  localparam logic [SX_W-1:0]  SX_LAST = SX_W'(CELL_W - 1);
  localparam logic [SY_W-1:0]  SY_LAST = SY_W'(CELL_H - 1);
  localparam logic [COL_W-1:0] CC_LAST = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] CR_LAST = ROW_W'(GRID_H - 1);

  logic [SX_W-1:0]  sx_q, sx_d;
  logic [SY_W-1:0]  sy_q, sy_d;
  logic [COL_W-1:0] cc_q, cc_d;
  logic [ROW_W-1:0] cr_q, cr_d;

  logic sx_last, cc_last, sy_last, cr_last;

  assign sx_last = (sx_q == SX_LAST);
  assign cc_last = (cc_q == CC_LAST);
  assign sy_last = (sy_q == SY_LAST);
  assign cr_last = (cr_q == CR_LAST);

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sx_d = sx_q;
    cc_d = cc_q;
    sy_d = sy_q;
    cr_d = cr_q;
    if (pix_adv_i) begin
      if (!sx_last) begin
        sx_d = sx_q + 1'b1;
      end else begin
        sx_d = '0;
        if (!cc_last) begin
          cc_d = cc_q + 1'b1;
        end else begin
          cc_d = '0;
          if (!sy_last) begin
            sy_d = sy_q + 1'b1;
          end else begin
            sy_d = '0;
            cr_d = cr_last ? '0 : cr_q + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: non-blocking assignments here so all counters update from pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sx_q <= '0;
      cc_q <= '0;
      sy_q <= '0;
      cr_q <= '0;
    end else begin
      sx_q <= sx_d;
      cc_q <= cc_d;
      sy_q <= sy_d;
      cr_q <= cr_d;
    end
  end

  assign cc_o  = cc_q;
  assign cr_o  = cr_q;
  assign sof_o = (sx_q == '0) && (cc_q == '0) && (sy_q == '0) && (cr_q == '0);
  assign eol_o = cc_last && sx_last;
  assign eof_o = eol_o && cr_last && sy_last;

endmodule

// File: rtl/grid_frame_ctrl.sv
// Double-buffered cell grid shared between the pixel streamer (reads) and a
// host writer; bank swaps happen only on the last pixel of a frame.
module grid_frame_ctrl
  import grid_pkg::*;
#(
  parameter int X_SIZE = DEF_X_SIZE,
  parameter int Y_SIZE = DEF_Y_SIZE,
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  localparam int CELL_W = X_SIZE / GRID_W,
  localparam int CELL_H = Y_SIZE / GRID_H,
  localparam int COL_W  = clog2_min1(GRID_W),
  localparam int ROW_W  = clog2_min1(GRID_H)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pix_adv,
  output logic             cell_state,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic             wr_data,
  output logic             wr_err,
  input  logic             commit_valid,
  output logic             commit_ready,
  output logic             bank_sel,
  output logic [15:0]      frame_cnt
);

  localparam int N_CELLS = GRID_W * GRID_H;
  localparam int IDX_W   = clog2_min1(N_CELLS);

  logic [COL_W-1:0] cc;
  logic [ROW_W-1:0] cr;

  grid_pos_counter #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H),
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_pos (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .pix_adv_i (pix_adv),
    .cc_o      (cc),
    .cr_o      (cr),
    .sof_o     (sof),
    .eol_o     (eol),
    .eof_o     (eof)
  );

  logic [N_CELLS-1:0] bank_q [2];
  logic [N_CELLS-1:0] bank_d [2];
  logic               bank_sel_q, bank_sel_d;
  logic [0:0]         state_q, state_d;
  logic               wr_err_q, wr_err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic             back_sel;
  logic             frame_end;
  logic             swap;
  logic             wr_fire;
  logic             col_oob, row_oob, wr_oob;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Range checks exist only when the index field can encode values past the grid
  if ((1 << COL_W) > GRID_W) begin : g_col_chk
    assign col_oob = (wr_col >= COL_W'(GRID_W));
  end else begin : g_col_full
    assign col_oob = 1'b0;
  end

  if ((1 << ROW_W) > GRID_H) begin : g_row_chk
    assign row_oob = (wr_row >= ROW_W'(GRID_H));
  end else begin : g_row_full
    assign row_oob = 1'b0;
  end

  assign back_sel  = ~bank_sel_q;
  assign frame_end = pix_adv & eof;
  assign swap      = (state_q == ST_PENDING) & frame_end;
  assign wr_ready  = (state_q == ST_IDLE);
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_oob    = col_oob | row_oob;
  assign wr_idx    = IDX_W'(cell_idx(32'(wr_row), 32'(wr_col), GRID_W));
  assign rd_idx    = IDX_W'(cell_idx(32'(cr), 32'(cc), GRID_W));

  always_comb begin
    bank_d      = bank_q;
    bank_sel_d  = bank_sel_q;
    state_d     = state_q;
    wr_err_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;

    if (wr_fire) begin
      if (wr_oob) wr_err_d = 1'b1;
      else        bank_d[back_sel][wr_idx] = wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_valid) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        // The outgoing front bank becomes the new back bank, seeded with the
        // image now on display so later edits are incremental.
        if (swap) begin
          state_d                = ST_IDLE;
          bank_sel_d             = back_sel;
          bank_d[bank_sel_q]     = bank_q[back_sel];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: the banks are a handful of flops and their contents are defined after reset, so they are cleared like any other state.
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      bank_sel_q  <= 1'b0;
      state_q     <= ST_IDLE;
      wr_err_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      bank_q      <= bank_d;
      bank_sel_q  <= bank_sel_d;
      state_q     <= state_d;
      wr_err_q    <= wr_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cell_state   = bank_q[bank_sel_q][rd_idx];
  assign commit_ready = swap;
  assign bank_sel     = bank_sel_q;
  assign wr_err       = wr_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_grid_frame_ctrl.sv
// Self-checking bench for grid_frame_ctrl on an 8x6 screen with a 4x3 grid;
// a pixel/grid reference model is compared against the DUT every cycle.
module tb_grid_frame_ctrl;

  localparam int XS = 8;
  localparam int YS = 6;
  localparam int GW = 4;
  localparam int GH = 3;
  localparam int CW = XS / GW;
  localparam int CH = YS / GH;
  localparam int NPIX = XS * YS;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        pix_adv = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_col = '0;
  logic [1:0]  wr_row = '0;
  logic        wr_data = 1'b0;
  logic        commit_valid = 1'b0;
  logic        cell_state, sof, eol, eof, wr_ready, wr_err, commit_ready, bank_sel;
  logic [15:0] frame_cnt;

  grid_frame_ctrl #(
    .X_SIZE (XS),
    .Y_SIZE (YS),
    .GRID_W (GW),
    .GRID_H (GH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .pix_adv      (pix_adv),
    .cell_state   (cell_state),
    .sof          (sof),
    .eol          (eol),
    .eof          (eof),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_col       (wr_col),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .bank_sel     (bank_sel),
    .frame_cnt    (frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: screen position in plain x/y, two images as 2-D grids
  bit          m_grid [2][GH][GW];
  int          m_x, m_y;
  bit          m_sel, m_pend, m_err;
  logic [15:0] m_frames;

  // Observation counters
  int ones, stray, cr_total, eol_cnt, adv_since;

  typedef struct {
    logic       adv, wv;
    logic [1:0] col, row;
    logic       d, cv;
    logic       e_sof, e_eol, e_eof, e_cs, e_wrdy, e_werr, e_crdy, e_bsel;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic adv, wv, input logic [1:0] col, row,
                              input logic d, cv, input logic s, l, f, we);
    vec_t v;
    v.adv = adv; v.wv = wv; v.col = col; v.row = row; v.d = d; v.cv = cv;
    v.e_sof = s; v.e_eol = l; v.e_eof = f; v.e_werr = we;
    v.e_cs = 1'b0; v.e_wrdy = 1'b1; v.e_crdy = 1'b0; v.e_bsel = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < GH; r++)
        for (int c = 0; c < GW; c++) m_grid[b][r][c] = 1'b0;
    m_x = 0; m_y = 0; m_sel = 0; m_pend = 0; m_err = 0; m_frames = '0;
    adv_since = 0;
  endtask

  task automatic model_step();
    bit at_eof, swap, acc, oob;
    at_eof = (m_x == XS - 1) && (m_y == YS - 1);
    swap   = m_pend && pix_adv && at_eof;
    acc    = wr_valid && !m_pend;
    oob    = (int'(wr_col) >= GW) || (int'(wr_row) >= GH);
    m_err  = acc && oob;
    if (acc && !oob) m_grid[!m_sel][wr_row][wr_col] = wr_data;
    if (!m_pend) begin
      if (commit_valid) m_pend = 1;
    end else if (swap) begin
      m_pend = 0;
      m_sel  = !m_sel;
      for (int r = 0; r < GH; r++)
        for (int c = 0; c < GW; c++) m_grid[!m_sel][r][c] = m_grid[m_sel][r][c];
    end
    if (pix_adv) begin
      m_x++;
      if (m_x == XS) begin
        m_x = 0; m_y++;
        if (m_y == YS) begin
          m_y = 0; m_frames++;
        end
      end
    end
  endtask

  task automatic check_model();
    bit e_eol, e_eof;
    e_eol = (m_x == XS - 1);
    e_eof = e_eol && (m_y == YS - 1);
    check("cell_state",   int'(cell_state),   int'(m_grid[m_sel][m_y / CH][m_x / CW]));
    check("sof",          int'(sof),          int'(m_x == 0 && m_y == 0));
    check("eol",          int'(eol),          int'(e_eol));
    check("eof",          int'(eof),          int'(e_eof));
    check("wr_ready",     int'(wr_ready),     int'(!m_pend));
    check("wr_err",       int'(wr_err),       int'(m_err));
    check("commit_ready", int'(commit_ready), int'(m_pend && pix_adv && e_eof));
    check("bank_sel",     int'(bank_sel),     int'(m_sel));
    check("frame_cnt",    int'(frame_cnt),    int'(m_frames));
  endtask

  task automatic apply(input logic adv, wv, input logic [1:0] col, row, input logic d, cv);
    pix_adv = adv; wr_valid = wv; wr_col = col; wr_row = row; wr_data = d; commit_valid = cv;
  endtask

  // Observes DUT outputs at the falling edge, then advances model and clock
  task automatic observe_and_tick();
    if (pix_adv) begin
      if (cell_state) begin
        ones++;
        if (!(m_x >= 4 && m_x <= 5 && m_y >= 2 && m_y <= 3)) stray++;
      end
      if (eol) eol_cnt++;
      adv_since++;
      if (eof) begin
        check("frame_len", adv_since, NPIX);
        adv_since = 0;
      end
    end
    if (commit_ready) cr_total++;
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic run(input logic adv, wv, input logic [1:0] col, row, input logic d, cv);
    apply(adv, wv, col, row, d, cv);
    @(negedge aclk);
    check_model();
    observe_and_tick();
  endtask

  task automatic reset_dut();
    aresetn = 1'b0;
    apply(0, 0, 0, 0, 0, 0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic check_reset();
    check("rst_sof",          int'(sof),          1);
    check("rst_eol",          int'(eol),          0);
    check("rst_eof",          int'(eof),          0);
    check("rst_cell_state",   int'(cell_state),   0);
    check("rst_wr_ready",     int'(wr_ready),     1);
    check("rst_wr_err",       int'(wr_err),       0);
    check("rst_commit_ready", int'(commit_ready), 0);
    check("rst_bank_sel",     int'(bank_sel),     0);
    check("rst_frame_cnt",    int'(frame_cnt),    0);
  endtask

  // Holds commit_valid with pix_adv high until commit_ready is seen
  task automatic do_commit();
    int seen;
    bit eof_at;
    seen = 0; eof_at = 0;
    for (int i = 0; i < 4 * NPIX && seen == 0; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      @(negedge aclk);
      check_model();
      if (commit_ready) begin
        seen++;
        eof_at = eof;
      end
      observe_and_tick();
    end
    apply(0, 0, 0, 0, 0, 0);
    check("commit_ready_seen", seen, 1);
    check("commit_ready_on_eof", int'(eof_at), 1);
  endtask

  task automatic run_frame_count();
    ones = 0; stray = 0; eol_cnt = 0;
    for (int i = 0; i < NPIX; i++) run(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ones = 0; stray = 0; cr_total = 0; eol_cnt = 0;
    model_reset();

    // Directed table from reset: position walk, eol, and an out-of-range row write
    tbl[0]  = mk(0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 2'd1, 2'd3, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);

    reset_dut();
    check_reset();
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].adv, tbl[i].wv, tbl[i].col, tbl[i].row, tbl[i].d, tbl[i].cv);
      @(negedge aclk);
      check($sformatf("tbl%0d_sof", i),   int'(sof),          int'(tbl[i].e_sof));
      check($sformatf("tbl%0d_eol", i),   int'(eol),          int'(tbl[i].e_eol));
      check($sformatf("tbl%0d_eof", i),   int'(eof),          int'(tbl[i].e_eof));
      check($sformatf("tbl%0d_cs", i),    int'(cell_state),   int'(tbl[i].e_cs));
      check($sformatf("tbl%0d_wrdy", i),  int'(wr_ready),     int'(tbl[i].e_wrdy));
      check($sformatf("tbl%0d_werr", i),  int'(wr_err),       int'(tbl[i].e_werr));
      check($sformatf("tbl%0d_crdy", i),  int'(commit_ready), int'(tbl[i].e_crdy));
      check($sformatf("tbl%0d_bsel", i),  int'(bank_sel),     int'(tbl[i].e_bsel));
      observe_and_tick();
    end

    // One full frame with pix_adv held high
    reset_dut();
    check_reset();
    run_frame_count();
    check("frame1_cnt", int'(frame_cnt), 1);
    check("frame1_eols", eol_cnt, YS);
    check("frame1_ones", ones, 0);
    check("frame1_sof_again", int'(sof), 1);

    // Write without commit stays invisible for two frames
    run(0, 1, 2'd2, 2'd1, 1, 0);
    run_frame_count();
    run_frame_count();
    check("nocommit_ones", ones, 0);
    check("nocommit_frames", int'(frame_cnt), 3);

    // Commit requested mid-frame, swap at eof, cell (2,1) appears
    for (int i = 0; i < 20; i++) run(1, 0, 0, 0, 0, 0);
    do_commit();
    check("commit1_bank_sel", int'(bank_sel), 1);
    run_frame_count();
    check("commit1_ones", ones, CW * CH);
    check("commit1_stray", stray, 0);

    // Second commit with no edits: image must be preserved by the back copy
    do_commit();
    check("commit2_bank_sel", int'(bank_sel), 0);
    run_frame_count();
    check("commit2_ones", ones, CW * CH);
    check("commit2_stray", stray, 0);

    // Out-of-range rows are dropped with a single-cycle wr_err
    run(0, 1, 2'd0, 2'd3, 1, 0);
    check("oob_r3c0_err", int'(wr_err), 1);
    run(0, 0, 2'd0, 2'd0, 0, 0);
    check("oob_r3c0_err_clear", int'(wr_err), 0);
    run(0, 1, 2'd3, 2'd3, 1, 0);
    check("oob_r3c3_err", int'(wr_err), 1);
    run(0, 0, 2'd0, 2'd0, 0, 0);
    do_commit();
    run_frame_count();
    check("oob_ones", ones, CW * CH);
    check("oob_stray", stray, 0);

    // Random stalls, writes and commits against the model
    for (int i = 0; i < 1500; i++) begin
      logic adv, wv, d, cv;
      logic [1:0] col, row;
      adv = 1'($urandom_range(0, 1));
      wv  = ($urandom_range(0, 3) == 0);
      col = 2'($urandom_range(0, 3));
      row = 2'($urandom_range(0, 3));
      d   = 1'($urandom_range(0, 1));
      cv  = m_pend ? 1'b1 : ($urandom_range(0, 59) == 0);
      run(adv, wv, col, row, d, cv);
    end

    // Reset while a commit is pending at pixel 20
    apply(0, 0, 0, 0, 0, 0);
    reset_dut();
    for (int i = 0; i < 20; i++) run(1, (i == 3), 2'd1, 2'd1, 1, 0);
    run(0, 0, 0, 0, 0, 1);
    check("pend_wr_ready", int'(wr_ready), 0);
    for (int i = 0; i < 3; i++) run(1, 0, 0, 0, 0, 1);
    cr_total = 0;
    reset_dut();
    check_reset();
    run_frame_count();
    check("rst_pend_no_commit", cr_total, 0);
    check("rst_pend_ones", ones, 0);
    check("rst_pend_frames", int'(frame_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
